// File: rtl/biquad_seq_ctrl.sv
// Sequencer and coefficient owner for one biquad IIR section: paces samples into the
// section at the multiplier stride, returns its output on a stream, applies coef commits between samples.
module biquad_seq_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 8,
  parameter int STRIDE    = 4,
  parameter int LAT       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [DATAWIDTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [DATAWIDTH-1:0] m_data,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_addr,
  input  logic signed [COEFWIDTH-1:0] cfg_wdata,
  output logic                        cfg_pending,
  output logic signed [DATAWIDTH-1:0] bq_x,
  output logic                        bq_valid,
  output logic                        bq_ce,
  output logic signed [COEFWIDTH-1:0] bq_a11,
  output logic signed [COEFWIDTH-1:0] bq_a12,
  output logic signed [COEFWIDTH-1:0] bq_b10,
  output logic signed [COEFWIDTH-1:0] bq_b11,
  output logic signed [COEFWIDTH-1:0] bq_b12,
  input  logic signed [DATAWIDTH-1:0] bq_yout
);

  localparam logic [3:0] STRIDE_M1 = 4'(STRIDE - 1);
  localparam logic [3:0] LAT_C     = 4'(LAT);
  // 0.5 in signed fractional format: unity-ish pass-through gain after reset
  localparam logic signed [COEFWIDTH-1:0] COEF_HALF = {2'b01, {(COEFWIDTH-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_STROBE, S_WAIT} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] prime_cnt;
  logic       commit;

  logic signed [COEFWIDTH-1:0] sh_a11, sh_a12, sh_b10, sh_b11, sh_b12;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LAT_C) ? LAT_C : 4'(v + 4'd1);
  endfunction

  assign commit  = cfg_we && (cfg_addr == 3'd7);
  assign s_ready = bq_ce && (state == S_IDLE) && !cfg_pending && en && (!m_valid || m_ready);

  // Shadow coefficient bank: writable at any time, copied to the active set only in APPLY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a11 <= '0;
      sh_a12 <= '0;
      sh_b10 <= COEF_HALF;
      sh_b11 <= '0;
      sh_b12 <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    sh_a11 <= cfg_wdata;
        3'd1:    sh_a12 <= cfg_wdata;
        3'd2:    sh_b10 <= cfg_wdata;
        3'd3:    sh_b11 <= cfg_wdata;
        3'd4:    sh_b12 <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      prime_cnt   <= '0;
      bq_ce       <= 1'b0;
      bq_valid    <= 1'b0;
      bq_x        <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      cfg_pending <= 1'b0;
      bq_a11      <= '0;
      bq_a12      <= '0;
      bq_b10      <= COEF_HALF;
      bq_b11      <= '0;
      bq_b12      <= '0;
    end else begin
      bq_ce <= 1'b1;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (commit) cfg_pending <= 1'b1;
      case (state)
        // Pending commits win over new samples so coefs change only between strides
        S_IDLE: begin
          if (cfg_pending) begin
            state <= S_APPLY;
          end else if (s_valid && s_ready) begin
            bq_x     <= s_data;
            bq_valid <= 1'b1;
            state    <= S_STROBE;
          end
        end
        S_APPLY: begin
          bq_a11 <= sh_a11;
          bq_a12 <= sh_a12;
          bq_b10 <= sh_b10;
          bq_b11 <= sh_b11;
          bq_b12 <= sh_b12;
          if (!commit) cfg_pending <= 1'b0;
          state <= S_IDLE;
        end
        // Section samples x on this clock
        S_STROBE: begin
          bq_valid  <= 1'b0;
          prime_cnt <= sat_inc(prime_cnt);
          wait_cnt  <= STRIDE_M1;
          state     <= S_WAIT;
        end
        // First WAIT clock captures yout; output only once the section is primed
        S_WAIT: begin
          if (wait_cnt == STRIDE_M1) begin
            m_data <= bq_yout;
            if (prime_cnt == LAT_C) m_valid <= 1'b1;
          end
          wait_cnt <= 4'(wait_cnt - 4'd1);
          if (wait_cnt == 4'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
